// File: rtl/aoi22_stim_sequencer.sv
// Drives all 16 input vectors into one AOI22X1, samples QN at the end of each hold, counts mismatches and QN toggles.
// Define STIM_GRAY_EN to sweep in Gray order instead of binary order.
module aoi22_stim_sequencer #(
   parameter int HOLD  = 4,
   parameter int LOOPS = 1,
   parameter int CNT_W = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   input  logic             QN,
   output logic             IN1,
   output logic             IN2,
   output logic             IN3,
   output logic             IN4,
   output logic             BUSY,
   output logic             DONE,
   output logic             PASS,
   output logic [CNT_W-1:0] ERR_CNT,
   output logic [CNT_W-1:0] TGL_CNT,
   output logic [3:0]       FAIL_VEC
);

   localparam int HOLD_W = (HOLD > 2) ? $clog2(HOLD) : 1;
   localparam int LOOP_W = (LOOPS > 1) ? $clog2(LOOPS) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD - 1);
   localparam logic [LOOP_W-1:0] LOOP_LAST = LOOP_W'(LOOPS - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_APPLY = 2'd1,
      S_FIN   = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [3:0]        idx_q, idx_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic [LOOP_W-1:0] loop_q, loop_d;
   logic              prev_q, prev_d;
   logic              first_q, first_d;
   logic [3:0]        stim_q, stim_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              pass_q, pass_d;
   logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
   logic [CNT_W-1:0]  tgl_cnt_q, tgl_cnt_d;
   logic [3:0]        fail_vec_q, fail_vec_d;
   logic [3:0]        cur_vec;

   function automatic logic [3:0] vec_of(input logic [3:0] i);
`ifdef STIM_GRAY_EN
      return i ^ (i >> 1);
`else
      return i;
`endif
   endfunction

   function automatic logic aoi22_ref(input logic [3:0] v);
      return ~((v[0] & v[1]) | (v[2] & v[3]));
   endfunction

   assign cur_vec = vec_of(idx_q);

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      hold_d     = hold_q;
      loop_d     = loop_q;
      prev_d     = prev_q;
      first_d    = first_q;
      stim_d     = stim_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      pass_d     = pass_q;
      err_cnt_d  = err_cnt_q;
      tgl_cnt_d  = tgl_cnt_q;
      fail_vec_d = fail_vec_q;

      case (state_q)
         S_IDLE: begin
            stim_d = 4'b0000;
            busy_d = 1'b0;
            if (START) begin
               err_cnt_d  = '0;
               tgl_cnt_d  = '0;
               fail_vec_d = 4'b0000;
               pass_d     = 1'b0;
               idx_d      = 4'd0;
               hold_d     = '0;
               loop_d     = '0;
               first_d    = 1'b1;
               stim_d     = vec_of(4'd0);
               busy_d     = 1'b1;
               state_d    = S_APPLY;
            end
         end

         S_APPLY: begin
            busy_d = 1'b1;
            stim_d = cur_vec;
            hold_d = hold_q + HOLD_W'(1);
            if (hold_q == HOLD_LAST) begin
               // QN here reflects the vector driven for the whole hold window
               if (QN != aoi22_ref(cur_vec)) begin
                  if (err_cnt_q != CNT_MAX)
                     err_cnt_d = err_cnt_q + CNT_W'(1);
                  if (err_cnt_q == '0)
                     fail_vec_d = cur_vec;
               end
               if (!first_q && (QN != prev_q) && (tgl_cnt_q != CNT_MAX))
                  tgl_cnt_d = tgl_cnt_q + CNT_W'(1);
               prev_d  = QN;
               first_d = 1'b0;
               hold_d  = '0;
               idx_d   = idx_q + 4'd1;
               stim_d  = vec_of(idx_d);
               if (idx_q == 4'd15) begin
                  loop_d = loop_q + LOOP_W'(1);
                  if (loop_q == LOOP_LAST) begin
                     state_d = S_FIN;
                     busy_d  = 1'b0;
                     done_d  = 1'b1;
                     stim_d  = 4'b0000;
                     pass_d  = (err_cnt_d == '0);
                  end
               end
            end
         end

         S_FIN: begin
            stim_d  = 4'b0000;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end

         default: begin
            stim_d  = 4'b0000;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= S_IDLE;
         idx_q      <= 4'd0;
         hold_q     <= '0;
         loop_q     <= '0;
         prev_q     <= 1'b0;
         first_q    <= 1'b0;
         stim_q     <= 4'b0000;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         pass_q     <= 1'b0;
         err_cnt_q  <= '0;
         tgl_cnt_q  <= '0;
         fail_vec_q <= 4'b0000;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         hold_q     <= hold_d;
         loop_q     <= loop_d;
         prev_q     <= prev_d;
         first_q    <= first_d;
         stim_q     <= stim_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         pass_q     <= pass_d;
         err_cnt_q  <= err_cnt_d;
         tgl_cnt_q  <= tgl_cnt_d;
         fail_vec_q <= fail_vec_d;
      end
   end

   assign IN1      = stim_q[0];
   assign IN2      = stim_q[1];
   assign IN3      = stim_q[2];
   assign IN4      = stim_q[3];
   assign BUSY     = busy_q;
   assign DONE     = done_q;
   assign PASS     = pass_q;
   assign ERR_CNT  = err_cnt_q;
   assign TGL_CNT  = tgl_cnt_q;
   assign FAIL_VEC = fail_vec_q;

endmodule

// File: tb/tb_aoi22_stim_sequencer.sv
// Bench for aoi22_stim_sequencer: three instances (1 loop/8-bit, 2 loops/3-bit, 2 loops/8-bit) each driving a behavioural AOI22.
module tb_aoi22_stim_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst = 1'b1;
   logic start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
   logic stuck_a = 1'b0, stuck_b = 1'b0, stuck_c = 1'b0;

   logic a1, a2, a3, a4, a_busy, a_done, a_pass, qn_a;
   logic b1, b2, b3, b4, b_busy, b_done, b_pass, qn_b;
   logic c1, c2, c3, c4, c_busy, c_done, c_pass, qn_c;
   logic [7:0] a_err, a_tgl, c_err, c_tgl;
   logic [2:0] b_err, b_tgl;
   logic [3:0] a_fail, b_fail, c_fail, a_vec;

   assign a_vec = {a4, a3, a2, a1};
   assign qn_a  = stuck_a ? 1'b1 : ~((a1 & a2) | (a3 & a4));
   assign qn_b  = stuck_b ? 1'b1 : ~((b1 & b2) | (b3 & b4));
   assign qn_c  = stuck_c ? 1'b1 : ~((c1 & c2) | (c3 & c4));

   aoi22_stim_sequencer #(.HOLD(4), .LOOPS(1), .CNT_W(8)) u_a (
      .CLK(clk), .RST(rst), .START(start_a), .QN(qn_a),
      .IN1(a1), .IN2(a2), .IN3(a3), .IN4(a4), .BUSY(a_busy), .DONE(a_done), .PASS(a_pass),
      .ERR_CNT(a_err), .TGL_CNT(a_tgl), .FAIL_VEC(a_fail));

   aoi22_stim_sequencer #(.HOLD(4), .LOOPS(2), .CNT_W(3)) u_b (
      .CLK(clk), .RST(rst), .START(start_b), .QN(qn_b),
      .IN1(b1), .IN2(b2), .IN3(b3), .IN4(b4), .BUSY(b_busy), .DONE(b_done), .PASS(b_pass),
      .ERR_CNT(b_err), .TGL_CNT(b_tgl), .FAIL_VEC(b_fail));

   aoi22_stim_sequencer #(.HOLD(4), .LOOPS(2), .CNT_W(8)) u_c (
      .CLK(clk), .RST(rst), .START(start_c), .QN(qn_c),
      .IN1(c1), .IN2(c2), .IN3(c3), .IN4(c4), .BUSY(c_busy), .DONE(c_done), .PASS(c_pass),
      .ERR_CNT(c_err), .TGL_CNT(c_tgl), .FAIL_VEC(c_fail));

`ifdef STIM_GRAY_EN
   localparam int EXP_TGL_1LOOP = 8;
   localparam int EXP_TGL_2LOOP = 16;
`else
   localparam int EXP_TGL_1LOOP = 5;
   localparam int EXP_TGL_2LOOP = 11;
`endif

   logic [3:0] exp_vec [16];
   int checks = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic busy_of(input int w);
      return (w == 0) ? a_busy : (w == 1) ? b_busy : c_busy;
   endfunction

   function automatic logic done_of(input int w);
      return (w == 0) ? a_done : (w == 1) ? b_done : c_done;
   endfunction

   task automatic set_start(input int w, input logic v);
      case (w)
         0: start_a = v;
         1: start_b = v;
         default: start_c = v;
      endcase
   endtask

   // Pulse START, then count APPLY cycles until DONE; returns sitting in the FIN cycle
   task automatic run(input int w, input string tag, output int cyc);
      bit seen;
      cyc  = 0;
      seen = 0;
      set_start(w, 1'b1);
      tick;
      set_start(w, 1'b0);
      for (int i = 0; i < 400; i++) begin
         if (done_of(w)) begin
            seen = 1;
            break;
         end
         if (busy_of(w)) cyc++;
         tick;
      end
      if (!seen) check({tag, "_done_timeout"}, 0, 1);
   endtask

   initial begin
`ifdef STIM_GRAY_EN
      exp_vec = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                  4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};
`else
      exp_vec = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7,
                  4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15};
`endif
   end

   initial begin
      int cyc;
      int done_cnt;
      int acc_cnt;
      logic busy_prev;

      rst = 1'b1;
      tick;
      tick;
      rst = 1'b0;
      check("rst_vec", a_vec, 0);
      check("rst_busy", a_busy, 0);
      check("rst_done", a_done, 0);
      check("rst_pass", a_pass, 0);
      check("rst_err", a_err, 0);
      check("rst_tgl", a_tgl, 0);
      check("rst_fail_vec", a_fail, 0);

      // Good cell, single sweep: vector order, hold length and result
      start_a = 1'b1;
      tick;
      start_a = 1'b0;
      for (int k = 0; k < 64; k++) begin
         check("sweep_vec", a_vec, exp_vec[k / 4]);
         check("sweep_busy", a_busy, 1);
         tick;
      end
      check("sweep_done", a_done, 1);
      check("sweep_busy_fin", a_busy, 0);
      check("sweep_vec_fin", a_vec, 0);
      check("sweep_err", a_err, 0);
      check("sweep_tgl", a_tgl, EXP_TGL_1LOOP);
      check("sweep_pass", a_pass, 1);
      check("sweep_fail_vec", a_fail, 0);
      tick;
      check("sweep_done_low", a_done, 0);
      check("sweep_pass_hold", a_pass, 1);
      check("sweep_tgl_hold", a_tgl, EXP_TGL_1LOOP);

      // Stuck-1 output
      stuck_a = 1'b1;
      run(0, "stuck", cyc);
      check("stuck_cycles", cyc, 64);
      check("stuck_err", a_err, 7);
      check("stuck_tgl", a_tgl, 0);
      check("stuck_fail_vec", a_fail, 4'b0011);
      check("stuck_pass", a_pass, 0);
      tick;
      stuck_a = 1'b0;

      // Two loops, 3-bit counters: 14 raw mismatches saturate at 7
      stuck_b = 1'b1;
      run(1, "sat", cyc);
      check("sat_cycles", cyc, 128);
      check("sat_err", b_err, 7);
      check("sat_tgl", b_tgl, 0);
      check("sat_fail_vec", b_fail, 4'b0011);
      check("sat_pass", b_pass, 0);
      tick;

      // Two loops, good cell: the last->first transition across sweeps counts
      run(2, "loop2", cyc);
      check("loop2_cycles", cyc, 128);
      check("loop2_tgl", c_tgl, EXP_TGL_2LOOP);
      check("loop2_err", c_err, 0);
      check("loop2_pass", c_pass, 1);
      tick;

      // Reset at APPLY cycle 20 aborts the run
      start_a = 1'b1;
      tick;
      start_a = 1'b0;
      for (int k = 0; k < 20; k++) tick;
      check("abort_tgl_before", a_tgl, 2);
      rst = 1'b1;
      tick;
      rst = 1'b0;
      check("abort_busy", a_busy, 0);
      check("abort_done", a_done, 0);
      check("abort_vec", a_vec, 0);
      check("abort_tgl", a_tgl, 0);
      check("abort_err", a_err, 0);
      check("abort_pass", a_pass, 0);
      done_cnt = 0;
      for (int k = 0; k < 70; k++) begin
         if (a_done || a_busy) done_cnt++;
         tick;
      end
      check("abort_stays_idle", done_cnt, 0);
      run(0, "rerun", cyc);
      check("rerun_cycles", cyc, 64);
      check("rerun_err", a_err, 0);
      check("rerun_tgl", a_tgl, EXP_TGL_1LOOP);
      check("rerun_pass", a_pass, 1);
      tick;

      // START held high: one DONE per accepted START, no queuing during APPLY
      done_cnt  = 0;
      acc_cnt   = 0;
      busy_prev = a_busy;
      start_a   = 1'b1;
      for (int i = 0; i < 140; i++) begin
         tick;
         if (i == 99) start_a = 1'b0;
         if (a_done) done_cnt++;
         if (a_busy && !busy_prev) acc_cnt++;
         busy_prev = a_busy;
      end
      check("held_done_pulses", done_cnt, 2);
      check("held_accepts", acc_cnt, 2);
      check("held_idle_end", a_busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
